// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage and the downstream decode logic:
// reset PC, the NOP word, and instruction field positions with extractors.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] NOP      = 32'd0;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;
    localparam int unsigned RD_MSB     = 26;
    localparam int unsigned RD_LSB     = 22;
    localparam int unsigned RS_MSB     = 21;
    localparam int unsigned RS_LSB     = 17;
    localparam int unsigned RT_MSB     = 16;
    localparam int unsigned RT_LSB     = 12;
    localparam int unsigned SHAMT_MSB  = 11;
    localparam int unsigned SHAMT_LSB  = 7;
    localparam int unsigned ALUOP_MSB  = 6;
    localparam int unsigned ALUOP_LSB  = 2;
    localparam int unsigned IMM_MSB    = 16;
    localparam int unsigned TARGET_MSB = 26;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [4:0] ir_rd(input logic [31:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [4:0] ir_rs(input logic [31:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] ir_rt(input logic [31:0] ir);
        return ir[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [4:0] ir_shamt(input logic [31:0] ir);
        return ir[SHAMT_MSB:SHAMT_LSB];
    endfunction

    function automatic logic [4:0] ir_alu_op(input logic [31:0] ir);
        return ir[ALUOP_MSB:ALUOP_LSB];
    endfunction

    function automatic logic [16:0] ir_immediate(input logic [31:0] ir);
        return ir[IMM_MSB:0];
    endfunction

    function automatic logic [26:0] ir_target(input logic [31:0] ir);
        return ir[TARGET_MSB:0];
    endfunction

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// Enable-and-flush pipeline latch for {pc, pc_plus1, ir, valid}.
// Flush inserts a bubble (NOP, invalid) while the pc fields hold.
module fetch_stage_fd_latch
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc_plus1,
    input  logic [31:0] d_ir,
    input  logic        d_valid,
    output logic [31:0] q_pc,
    output logic [31:0] q_pc_plus1,
    output logic [31:0] q_ir,
    output logic        q_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus1_q, pc_plus1_d;
    logic [31:0] ir_q, ir_d;
    logic        valid_q, valid_d;

    // Next-state selection: flush beats enable, otherwise hold.
    always_comb begin
        pc_d       = pc_q;
        pc_plus1_d = pc_plus1_q;
        ir_d       = ir_q;
        valid_d    = valid_q;
        if (flush) begin
            ir_d    = NOP;
            valid_d = 1'b0;
        end else if (en) begin
            pc_d       = d_pc;
            pc_plus1_d = d_pc_plus1;
            ir_d       = d_ir;
            valid_d    = d_valid;
        end else begin
            valid_d = valid_q;
        end
    end

    // Latch state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= 32'd0;
            pc_plus1_q <= 32'd0;
            ir_q       <= NOP;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_plus1_q <= pc_plus1_d;
            ir_q       <= ir_d;
            valid_q    <= valid_d;
        end
    end

    assign q_pc       = pc_q;
    assign q_pc_plus1 = pc_plus1_q;
    assign q_ir       = ir_q;
    assign q_valid    = valid_q;

endmodule

// File: rtl/thirtytwo_bit_adder.sv
// 32-bit adder with carry-in and carry-out.
module thirtytwo_bit_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, and fills the F/D latch.
// Priority per edge is reset > redirect > stall > advance.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_pc_plus1,
    output logic [31:0] fd_ir,
    output logic        fd_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus1_s;
    logic        pc_cout_unused_s;

    thirtytwo_bit_adder u_pc_inc (
        .a    (pc_q),
        .b    (32'd1),
        .cin  (1'b0),
        .sum  (pc_plus1_s),
        .cout (pc_cout_unused_s)
    );

    // Next PC: redirect overrides stall; wrap past FFFF_FFFF is intentional.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus1_s;
        end
    end

    // PC register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign address_imem = pc_q;

    fetch_stage_fd_latch u_fd (
        .clock      (clock),
        .reset      (reset),
        .en         (~stall),
        .flush      (redirect),
        .d_pc       (pc_q),
        .d_pc_plus1 (pc_plus1_s),
        .d_ir       (q_imem),
        .d_valid    (1'b1),
        .q_pc       (fd_pc),
        .q_pc_plus1 (fd_pc_plus1),
        .q_ir       (fd_ir),
        .q_valid    (fd_valid)
    );

endmodule
